// File: rtl/c1tx_write_arbiter.sv
// c1tx_write_arbiter: shares the CCI-P c1 write-request channel among NUM_REQ
// requesters with round-robin grants, tracks writes in flight per requester
// from c1 responses, and offers a drain handshake for the controlling FSM.
// Optional feature macro: C1ARB_STRICT_PRIO0_EN (requester 0 gets strict priority).
module c1tx_write_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned MAX_OUTSTANDING = 64
) (
   input  logic                   clk,
   input  logic                   Resetb,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*42-1:0]  req_addr,
   input  logic [NUM_REQ*512-1:0] req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic                   c1TxAlmFull,
   output logic                   c1tx_valid,
   output logic [41:0]            c1tx_addr,
   output logic [511:0]           c1tx_data,
   output logic [15:0]            c1tx_mdata,
   input  logic                   c1rx_rspValid,
   input  logic [15:0]            c1rx_mdata,
   input  logic                   drain,
   output logic                   drain_done,
   output logic [NUM_REQ-1:0]     outstanding_zero,
   output logic                   err
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned IdxW = 3;

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   state_e             r_state;
   logic [CntW-1:0]    r_cnt [NUM_REQ];
   logic [IdxW-1:0]    r_last_grant;
   logic               r_c1tx_valid;
   logic [41:0]        r_c1tx_addr;
   logic [511:0]       r_c1tx_data;
   logic [15:0]        r_c1tx_mdata;
   logic               r_err;

   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_grant_vld;
   logic [IdxW-1:0]    w_grant_idx;
   logic [41:0]        w_sel_addr;
   logic [511:0]       w_sel_data;
   logic [IdxW-1:0]    w_rsp_idx;
   logic               w_rsp_bad_tag;
   logic               w_rsp_hit_zero;
   logic               w_rsp_err;
   logic               w_rsp_ok;
   logic [NUM_REQ-1:0] w_dec;
   logic               w_all_zero;

   // Lane eligibility: running, below its cap, channel not almost full.
   // Gated by reset so no grant is offered while reset is held.
   always_comb begin
      w_eligible = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_eligible[i] = req_valid[i] & (r_cnt[i] < CntW'(MAX_OUTSTANDING)) & ~c1TxAlmFull &
                         (r_state == StRun) & Resetb;
      end
   end

   // Round-robin pick starting after the last granted lane.
   always_comb begin
      int unsigned v_idx;
      v_idx       = 0;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
`ifdef C1ARB_STRICT_PRIO0_EN
      if (w_eligible[0]) begin
         w_grant_vld = 1'b1;
         w_grant_idx = '0;
      end else begin
         // Lanes 1..NUM_REQ-1 form their own ring; r_last_grant never holds 0 here.
         for (int unsigned k = 1; k < NUM_REQ; k++) begin
            v_idx = ((32'(r_last_grant) - 1 + k) % (NUM_REQ - 1)) + 1;
            if (!w_grant_vld && w_eligible[IdxW'(v_idx)]) begin
               w_grant_vld = 1'b1;
               w_grant_idx = IdxW'(v_idx);
            end
         end
      end
`else
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         v_idx = (32'(r_last_grant) + k) % NUM_REQ;
         if (!w_grant_vld && w_eligible[IdxW'(v_idx)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = IdxW'(v_idx);
         end
      end
`endif
   end

   // One-hot grant vector and the address/data of the granted lane.
   always_comb begin
      w_grant    = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_grant[i] = w_grant_vld && (w_grant_idx == IdxW'(i));
         if (w_grant[i]) begin
            w_sel_addr = req_addr[42*i +: 42];
            w_sel_data = req_data[512*i +: 512];
         end
      end
   end

   assign req_ready = w_grant;

   // Response decode: malformed tags or responses to an idle lane are errors, not decrements.
   always_comb begin
      w_rsp_idx      = c1rx_mdata[2:0];
      w_rsp_bad_tag  = (c1rx_mdata[15:3] != '0) || ({29'd0, w_rsp_idx} >= NUM_REQ);
      w_rsp_hit_zero = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_rsp_idx == IdxW'(i)) w_rsp_hit_zero = (r_cnt[i] == '0);
      end
      w_rsp_err = c1rx_rspValid & (w_rsp_bad_tag | w_rsp_hit_zero);
      w_rsp_ok  = c1rx_rspValid & ~w_rsp_err;
      w_dec     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_dec[i] = w_rsp_ok && (w_rsp_idx == IdxW'(i));
      end
   end

   // Per-lane in-flight counters; grant and response in the same cycle cancel.
   always_ff @(posedge clk or negedge Resetb) begin
      if (!Resetb) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            else if (w_dec[i] && !w_grant[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
         end
      end
   end

   // Round-robin pointer moves only on an actual grant.
   always_ff @(posedge clk or negedge Resetb) begin
      if (!Resetb) begin
         r_last_grant <= IdxW'(NUM_REQ - 1);
      end else begin
`ifdef C1ARB_STRICT_PRIO0_EN
         if (w_grant_vld && (w_grant_idx != '0)) r_last_grant <= w_grant_idx;
`else
         if (w_grant_vld) r_last_grant <= w_grant_idx;
`endif
      end
   end

   // Output register: one write per grant, presented the following cycle.
   always_ff @(posedge clk or negedge Resetb) begin
      if (!Resetb) begin
         r_c1tx_valid <= 1'b0;
         r_c1tx_addr  <= '0;
         r_c1tx_data  <= '0;
         r_c1tx_mdata <= '0;
      end else begin
         r_c1tx_valid <= w_grant_vld;
         if (w_grant_vld) begin
            r_c1tx_addr  <= w_sel_addr;
            r_c1tx_data  <= w_sel_data;
            r_c1tx_mdata <= {13'd0, w_grant_idx};
         end
      end
   end

   // Drain FSM: wait until every counter is zero and nothing sits in the output register.
   always_ff @(posedge clk or negedge Resetb) begin
      if (!Resetb) begin
         r_state <= StRun;
      end else begin
         unique case (r_state)
            StRun:   if (drain) r_state <= StDrain;
            StDrain: if (w_all_zero && !r_c1tx_valid) r_state <= StDone;
            StDone:  r_state <= StRun;
            default: r_state <= StRun;
         endcase
      end
   end

   // Sticky protocol error flag.
   always_ff @(posedge clk or negedge Resetb) begin
      if (!Resetb) r_err <= 1'b0;
      else if (w_rsp_err) r_err <= 1'b1;
   end

   // Per-lane idle flags straight from the counter registers.
   always_comb begin
      outstanding_zero = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) outstanding_zero[i] = (r_cnt[i] == '0);
   end

   assign w_all_zero = &outstanding_zero;
   assign c1tx_valid = r_c1tx_valid;
   assign c1tx_addr  = r_c1tx_addr;
   assign c1tx_data  = r_c1tx_data;
   assign c1tx_mdata = r_c1tx_mdata;
   assign drain_done = (r_state == StDone);
   assign err        = r_err;

endmodule

// File: tb/tb_c1tx_write_arbiter.sv
// Bench for c1tx_write_arbiter: random traffic against a cycle-level reference model
// built from the arbitration, counting and drain rules. Honours C1ARB_STRICT_PRIO0_EN.
module tb_c1tx_write_arbiter;

   localparam int N    = 4;
   localparam int MAXO = 4;

   logic             clk;
   logic             Resetb;
   logic [N-1:0]     req_valid;
   logic [N*42-1:0]  req_addr;
   logic [N*512-1:0] req_data;
   logic [N-1:0]     req_ready;
   logic             c1TxAlmFull;
   logic             c1tx_valid;
   logic [41:0]      c1tx_addr;
   logic [511:0]     c1tx_data;
   logic [15:0]      c1tx_mdata;
   logic             c1rx_rspValid;
   logic [15:0]      c1rx_mdata;
   logic             drain;
   logic             drain_done;
   logic [N-1:0]     outstanding_zero;
   logic             err;

   c1tx_write_arbiter #(
      .NUM_REQ         (N),
      .MAX_OUTSTANDING (MAXO)
   ) u_dut (
      .clk              (clk),
      .Resetb           (Resetb),
      .req_valid        (req_valid),
      .req_addr         (req_addr),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .c1TxAlmFull      (c1TxAlmFull),
      .c1tx_valid       (c1tx_valid),
      .c1tx_addr        (c1tx_addr),
      .c1tx_data        (c1tx_data),
      .c1tx_mdata       (c1tx_mdata),
      .c1rx_rspValid    (c1rx_rspValid),
      .c1rx_mdata       (c1rx_mdata),
      .drain            (drain),
      .drain_done       (drain_done),
      .outstanding_zero (outstanding_zero),
      .err              (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int           m_cnt [N];
   int           m_last;
   int           m_phase;   // 0 running, 1 draining, 2 drain complete
   bit           m_vld;
   logic [41:0]  m_addr;
   logic [511:0] m_data;
   logic [15:0]  m_mdata;
   bit           m_err;
   int           m_q[$];    // lanes of writes still awaiting a response

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_last  = N - 1;
      m_phase = 0;
      m_vld   = 0;
      m_addr  = '0;
      m_data  = '0;
      m_mdata = '0;
      m_err   = 0;
      m_q.delete();
   endtask

   // Lane the spec's rules say should be granted now, or -1.
   function automatic int pick();
      int i;
      if (m_phase != 0 || c1TxAlmFull) return -1;
`ifdef C1ARB_STRICT_PRIO0_EN
      if (req_valid[0] && m_cnt[0] < MAXO) return 0;
      for (int k = 1; k < N; k++) begin
         i = ((m_last - 1 + k) % (N - 1)) + 1;
         if (req_valid[i] && m_cnt[i] < MAXO) return i;
      end
`else
      for (int k = 1; k <= N; k++) begin
         i = (m_last + k) % N;
         if (req_valid[i] && m_cnt[i] < MAXO) return i;
      end
`endif
      return -1;
   endfunction

   task automatic model_step(input int g);
      int nph;
      int ri;
      bit zero_all;
      bit dec;
      zero_all = 1;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) zero_all = 0;
      case (m_phase)
         0:       nph = drain ? 1 : 0;
         1:       nph = (zero_all && !m_vld) ? 2 : 1;
         default: nph = 0;
      endcase
      dec = 0;
      ri  = 0;
      if (c1rx_rspValid) begin
         ri = int'(c1rx_mdata[2:0]);
         if (c1rx_mdata[15:3] != 0 || ri >= N || m_cnt[ri] == 0) m_err = 1;
         else dec = 1;
      end
      if (dec) m_cnt[ri]--;
      if (g >= 0) begin
         m_cnt[g]++;
`ifdef C1ARB_STRICT_PRIO0_EN
         if (g != 0) m_last = g;
`else
         m_last = g;
`endif
         m_vld   = 1;
         m_addr  = req_addr[42*g +: 42];
         m_data  = req_data[512*g +: 512];
         m_mdata = 16'(g);
         m_q.push_back(g);
      end else begin
         m_vld = 0;
      end
      m_phase = nph;
   endtask

   // Drive one cycle's inputs; a legal response is drawn from the in-flight queue.
   task automatic drive(input logic [N-1:0] v, input bit alm, input int p_rsp, input bit drn);
      int j;
      req_valid   = v;
      c1TxAlmFull = alm;
      drain       = drn;
      for (int i = 0; i < N; i++) req_addr[42*i +: 42] = 42'({$urandom(), $urandom()});
      for (int w = 0; w < N * 16; w++) req_data[32*w +: 32] = $urandom();
      c1rx_rspValid = 1'b0;
      c1rx_mdata    = '0;
      if (m_q.size() > 0 && int'($urandom_range(0, 99)) < p_rsp) begin
         j = int'($urandom_range(0, m_q.size() - 1));
         c1rx_rspValid = 1'b1;
         c1rx_mdata    = 16'(m_q[j]);
         m_q.delete(j);
      end
   endtask

   // Called at a falling edge with inputs driven; returns at the next falling edge.
   task automatic cycle();
      int g;
      logic [N-1:0] er;
      logic [N-1:0] ez;
      #1;
      g  = pick();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      @(posedge clk);
      model_step(g);
      #1;
      chk("c1tx_valid", c1tx_valid, m_vld);
      if (m_vld) begin
         chk("c1tx_addr", c1tx_addr, m_addr);
         chk("c1tx_data", c1tx_data, m_data);
         chk("c1tx_mdata", c1tx_mdata, m_mdata);
      end
      for (int i = 0; i < N; i++) ez[i] = (m_cnt[i] == 0);
      chk("outstanding_zero", outstanding_zero, ez);
      chk("err", err, m_err);
      chk("drain_done", drain_done, m_phase == 2);
      @(negedge clk);
   endtask

   task automatic chk_reset_values();
      chk("rst_req_ready", req_ready, '0);
      chk("rst_c1tx_valid", c1tx_valid, 1'b0);
      chk("rst_c1tx_addr", c1tx_addr, '0);
      chk("rst_c1tx_data", c1tx_data, '0);
      chk("rst_c1tx_mdata", c1tx_mdata, '0);
      chk("rst_drain_done", drain_done, 1'b0);
      chk("rst_outstanding_zero", outstanding_zero, {N{1'b1}});
      chk("rst_err", err, 1'b0);
   endtask

   initial begin
      bit got_done;
      Resetb        = 1'b0;
      req_valid     = '0;
      req_addr      = '0;
      req_data      = '0;
      c1TxAlmFull   = 1'b0;
      c1rx_rspValid = 1'b0;
      c1rx_mdata    = '0;
      drain         = 1'b0;
      model_reset();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values();
      @(negedge clk);
      Resetb = 1'b1;

      // All lanes valid: round-robin from lane 0, first with no responses
      for (int c = 0; c < 4; c++) begin drive(4'hF, 1'b0, 0, 1'b0); cycle(); end
      for (int c = 0; c < 30; c++) begin drive(4'hF, 1'b0, 60, 1'b0); cycle(); end

      // Lane 2 alone with a 3-cycle almost-full window
      for (int c = 0; c < 12; c++) begin
         drive(4'b0100, (c >= 5 && c < 8), 70, 1'b0);
         cycle();
      end

      // Random traffic
      for (int c = 0; c < 300; c++) begin
         drive(N'($urandom()), ($urandom_range(0, 99) < 20), 40, 1'b0);
         cycle();
      end

      // Return everything, then fill lane 1 to its cap and free one slot
      for (int c = 0; c < 100 && m_q.size() > 0; c++) begin drive('0, 1'b0, 100, 1'b0); cycle(); end
      for (int c = 0; c < 8; c++) begin drive(4'b0010, 1'b0, 0, 1'b0); cycle(); end
      drive(4'b0010, 1'b0, 0, 1'b0);
      c1rx_rspValid = 1'b1;
      c1rx_mdata    = 16'd1;
      void'(m_q.pop_front());
      cycle();
      for (int c = 0; c < 4; c++) begin drive(4'b0010, 1'b0, 0, 1'b0); cycle(); end

      // Build traffic, then drain with responses trickling back
      for (int c = 0; c < 10; c++) begin drive(4'hF, 1'b0, 10, 1'b0); cycle(); end
      got_done = 0;
      for (int c = 0; c < 300 && !got_done; c++) begin
         drive(N'($urandom()), 1'b0, 30, 1'b1);
         cycle();
         if (drain_done === 1'b1) got_done = 1;
      end
      chk("drain_completes", got_done, 1'b1);
      for (int c = 0; c < 3; c++) begin drive('0, 1'b0, 0, 1'b0); cycle(); end

      // Protocol errors: index out of range, idle lane, nonzero upper tag bits
      drive('0, 1'b0, 0, 1'b0);
      c1rx_rspValid = 1'b1;
      c1rx_mdata    = 16'h0007;
      cycle();
      drive('0, 1'b0, 0, 1'b0);
      c1rx_rspValid = 1'b1;
      c1rx_mdata    = 16'h0002;
      cycle();
      drive(4'b0001, 1'b0, 0, 1'b0);
      cycle();
      drive('0, 1'b0, 0, 1'b0);
      c1rx_rspValid = 1'b1;
      c1rx_mdata    = 16'h0008;
      cycle();
      for (int c = 0; c < 20; c++) begin
         drive(N'($urandom()), 1'b0, 50, 1'b0);
         cycle();
      end

      // Asynchronous reset in the middle of traffic
      drive(4'hF, 1'b0, 30, 1'b0);
      #2;
      Resetb = 1'b0;
      #1;
      model_reset();
      chk_reset_values();
      @(posedge clk);
      #1;
      chk_reset_values();
      @(negedge clk);
      Resetb = 1'b1;
      for (int c = 0; c < 40; c++) begin
         drive(N'($urandom()), ($urandom_range(0, 99) < 15), 50, 1'b0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/c1tx_write_arbiter.md
# c1tx_write_arbiter

Shares the single CCI-P c1 write-request channel among NUM_REQ independent write requesters, such as the update-bin writer, the status-line writer and future per-PE writers. It sits between the application datapath and the c1 Tx FIFO. It issues at most one WrLine per cycle under c1TxAlmFull backpressure and tags each write with its requester index in mdata. It tracks outstanding writes per requester from c1 responses and provides a drain handshake, so the controlling FSM knows when every issued write has been acknowledged.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_OUTSTANDING, 64: per-requester cap on writes in flight (power of 2, ≤ 256).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- Resetb  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_addr  in  NUM_REQ*42  line address; requester i occupies bits [42i+41:42i].
- req_data  in  NUM_REQ*512  line data; requester i occupies bits [512i+511:512i].
- req_ready  out  NUM_REQ  one-hot grant; the write is consumed when valid&ready.
- c1TxAlmFull  in  1  channel almost full; no grant while it is high.
- c1tx_valid  out  1  write request valid (eREQ_WRLINE_I, eVC_VA, eCL_LEN_1, sop=1).
- c1tx_addr  out  42  line address.
- c1tx_data  out  512  line data.
- c1tx_mdata  out  16  {13'b0, requester index[2:0]}.
- c1rx_rspValid  in  1  write response valid.
- c1rx_mdata  in  16  response mdata.
- drain  in  1  level request: stop granting and wait for all responses.
- drain_done  out  1  one-cycle pulse when the drain completes.
- outstanding_zero  out  NUM_REQ  requester i has no writes in flight.
- err  out  1  sticky protocol error.

## Operation
- FSM states: RUN (reset state), DRAIN, DONE.
- RUN → DRAIN when drain=1.
- DRAIN → DONE when all counters are 0 and no issue is pending in the output register.
- DONE → RUN unconditionally. drain_done=1 only in DONE.
- A drain that is still high in RUN after DONE re-enters DRAIN. A second pulse is legal.
- Grant in RUN only. eligible[i] = req_valid[i] & (cnt[i] < MAX_OUTSTANDING) & ~c1TxAlmFull.
- Round-robin: the search starts at last_grant+1 modulo NUM_REQ. last_grant updates only on an actual grant.
- At most one req_ready bit is high per cycle. req_ready is combinational from eligible and the pointer, with no dependency on req_valid of the granted lane beyond eligibility.
- On a grant, the output register loads the address/data of lane i, c1tx_mdata = i, and c1tx_valid=1 for exactly one cycle.
- Counter cnt[i] is $clog2(MAX_OUTSTANDING)+1 bits wide. It increments on grant to i and decrements on rspValid with c1rx_mdata[2:0]=i. Both in one cycle for the same i: unchanged.
- Response with index ≥ NUM_REQ, with nonzero c1rx_mdata[15:3], or targeting cnt=0: ignored for counting, err set to 1 until reset.
- outstanding_zero[i] = (cnt[i]==0), combinational from the counter register.

## Timing
- Grant cycle N gives c1tx_valid at N+1 (1-cycle latency). Back-to-back grants give one write per cycle.
- c1TxAlmFull is sampled in the grant cycle. A write already registered is still emitted; the FIFO threshold absorbs it.
- Response at cycle N is reflected in cnt/outstanding_zero at N+1.
- Reset values: req_ready=0, c1tx_valid=0, c1tx_addr=0, c1tx_data=0, c1tx_mdata=0, drain_done=0, outstanding_zero=all 1, err=0, counters 0, last_grant=NUM_REQ-1, state RUN.
- Reset asserted mid-operation clears everything immediately. In-flight responses that arrive later hit cnt=0 and set err; the controller must not reset with writes outstanding.

## Configuration
- C1ARB_STRICT_PRIO0_EN defined: requester 0 wins whenever it is eligible. The other lanes stay round-robin among themselves, and last_grant tracks only lanes 1..NUM_REQ-1.
- Undefined: pure round-robin across all lanes.

## Test plan
- Reset then all 4 lanes valid continuously, almFull=0 → grants 0,1,2,3,0,…, one c1tx_valid per cycle; mdata matches the lane; addr/data match the granted lane.
- Lane 2 valid alone, almFull raised at cycle 5 for 3 cycles → exactly 5 writes before the stall, no req_ready during almFull, resume at cycle 8.
- MAX_OUTSTANDING=4, lane 1 valid, no responses → 4 writes then ready=0; one response with mdata=1 → exactly one more write.
- Issue 10 writes across lanes, assert drain, return responses over 20 cycles → no grants after drain; drain_done pulses one cycle, one cycle after the last count reaches 0.
- Response mdata=7 with NUM_REQ=4, and a response to an idle lane → counters unchanged, err=1 and it stays 1.
- With C1ARB_STRICT_PRIO0_EN, lanes 0 and 3 valid continuously → only lane 0 granted; lane 0 dropped → lane 3 granted next cycle.
